// File: rtl/doorlock_pkg.sv
// -----------------------------------------------------------------------------
// doorlock_pkg
// Shared definitions for the keypad entry path of the door lock:
//   - state_t      : attempt sequencer states (IDLE, ENTRY, CHECK, LOCKOUT)
//   - key codes    : KEY_CLEAR, KEY_ENTER, PAD_NIBBLE
//   - EMPTY_VALUE  : 128-bit buffer with every nibble padded
//   - default parameter values and the shared timer width
//   - is_digit()   : classifies a key code as a decimal digit
// -----------------------------------------------------------------------------
package doorlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [3:0]   KEY_CLEAR   = 4'hA;
    localparam logic [3:0]   KEY_ENTER   = 4'hB;
    localparam logic [3:0]   PAD_NIBBLE  = 4'hF;
    localparam logic [127:0] EMPTY_VALUE = {32{PAD_NIBBLE}};

    localparam int DEF_MAX_DIGITS     = 32;
    localparam int DEF_MIN_DIGITS     = 4;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 1000;
    localparam int DEF_TIMEOUT_CYCLES = 5000;

    // Wide enough for the longer of the lockout and timeout loads.
    localparam int TMR_W = 13;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/entry_timer.sv
// -----------------------------------------------------------------------------
// entry_timer
// Loadable down-counter with a done flag. Shared by the lockout period and the
// optional entry timeout; the sequencer never needs both at the same time.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : load i_load_val this cycle (has priority over i_en)
//   i_load_val   : value to load
//   i_en         : decrement by one (holds at zero)
//   o_done       : count is zero
// -----------------------------------------------------------------------------
module entry_timer
    import doorlock_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [TMR_W-1:0] r_count;
    logic [TMR_W-1:0] w_count_nxt;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        w_count_nxt = r_count;
        if (i_load) begin
            w_count_nxt = i_load_val;
        end else if (i_en && (r_count != {TMR_W{1'b0}})) begin
            w_count_nxt = r_count - {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {TMR_W{1'b0}};
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_done = (r_count == {TMR_W{1'b0}});

endmodule

// File: rtl/keypad_entry_buffer.sv
// -----------------------------------------------------------------------------
// keypad_entry_buffer
// Collects keypad digits into the 128-bit value checked by the password
// comparators, sequences one compare per attempt, counts failed attempts and
// enforces a lockout period after too many consecutive failures.
// Optional feature macro: ENTRY_TIMEOUT_EN -- abandons an attempt after
// TIMEOUT_CYCLES clocks without a key (no fail pulse, fail count unchanged).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   key_valid/key_code: one-cycle key strobe; 0-9 digit, A clear, B enter
//   same/master_same  : comparator results, sampled while confirm is high
//   input_value       : packed digits, newest digit in the LSB nibble
//   confirm           : high for the single CHECK cycle
//   digit_count       : digits currently held
//   unlock/master_unlock/fail : one-cycle result pulses
//   locked            : high throughout the lockout period
// -----------------------------------------------------------------------------
module keypad_entry_buffer
    import doorlock_pkg::*;
#(
    parameter int MAX_DIGITS     = DEF_MAX_DIGITS,
    parameter int MIN_DIGITS     = DEF_MIN_DIGITS,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         same,
    input  logic         master_same,
    output logic [127:0] input_value,
    output logic         confirm,
    output logic [5:0]   digit_count,
    output logic         unlock,
    output logic         master_unlock,
    output logic         fail,
    output logic         locked
);

    state_t         r_state;
    state_t         w_next_state;

    logic [127:0]   r_value;
    logic [127:0]   w_value_nxt;
    logic [5:0]     r_count;
    logic [5:0]     w_count_nxt;
    logic [1:0]     r_fails;
    logic [1:0]     w_fails_nxt;
    logic [1:0]     w_fails_inc;

    logic           r_unlock;
    logic           r_master;
    logic           r_fail;
    logic           r_confirm;
    logic           r_locked;
    logic           w_unlock_nxt;
    logic           w_master_nxt;
    logic           w_fail_nxt;

    logic           w_digit;
    logic           w_clear;
    logic           w_enter;
    logic           w_full;
    logic           w_short;
    logic           w_fail_hit;
    logic           w_timeout;

    logic           w_tmr_load;
    logic           w_tmr_en;
    logic [TMR_W-1:0] w_tmr_load_val;
    logic           w_tmr_done;

    assign w_digit = key_valid && is_digit(key_code);
    assign w_clear = key_valid && (key_code == KEY_CLEAR);
    assign w_enter = key_valid && (key_code == KEY_ENTER);
    assign w_full  = (r_count >= 6'(MAX_DIGITS));
    assign w_short = (r_count < 6'(MIN_DIGITS));

    // Saturating increment; w_fail_hit means this failure starts a lockout.
    assign w_fails_inc = (r_fails == 2'(MAX_FAILS)) ? r_fails : (r_fails + 2'd1);
    assign w_fail_hit  = (w_fails_inc == 2'(MAX_FAILS));

`ifdef ENTRY_TIMEOUT_EN
    // A key acted on in the same cycle as expiry takes precedence.
    assign w_timeout = (r_state == ST_ENTRY) && w_tmr_done &&
                       !(w_digit || w_clear || w_enter);
`else
    assign w_timeout = 1'b0;
`endif

    entry_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_digit) begin
                    w_next_state = ST_ENTRY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (w_clear || w_timeout) begin
                    w_next_state = ST_IDLE;
                end else if (w_enter) begin
                    if (!w_short) begin
                        w_next_state = ST_CHECK;
                    end else if (w_fail_hit) begin
                        w_next_state = ST_LOCKOUT;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_ENTRY;
                end
            end
            ST_CHECK: begin
                if (master_same || same || !w_fail_hit) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (w_tmr_done) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_LOCKOUT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values for the current state and key.
    always_comb begin
        w_value_nxt    = r_value;
        w_count_nxt    = r_count;
        w_fails_nxt    = r_fails;
        w_unlock_nxt   = 1'b0;
        w_master_nxt   = 1'b0;
        w_fail_nxt     = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_en       = 1'b0;
        w_tmr_load_val = {TMR_W{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_digit) begin
                    w_value_nxt = {r_value[123:0], key_code};
                    w_count_nxt = 6'd1;
`ifdef ENTRY_TIMEOUT_EN
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                end else begin
                    w_value_nxt = r_value;
                end
            end
            ST_ENTRY: begin
                if (w_digit) begin
                    // A full buffer drops further digits without comment.
                    if (!w_full) begin
                        w_value_nxt = {r_value[123:0], key_code};
                        w_count_nxt = r_count + 6'd1;
                    end else begin
                        w_value_nxt = r_value;
                    end
`ifdef ENTRY_TIMEOUT_EN
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                end else if (w_clear || w_timeout) begin
                    w_value_nxt = EMPTY_VALUE;
                    w_count_nxt = 6'd0;
                end else if (w_enter) begin
                    // Too-short entries fail without consulting the comparators.
                    if (w_short) begin
                        w_value_nxt = EMPTY_VALUE;
                        w_count_nxt = 6'd0;
                        w_fail_nxt  = 1'b1;
                        w_fails_nxt = w_fails_inc;
                        if (w_fail_hit) begin
                            w_tmr_load     = 1'b1;
                            w_tmr_load_val = TMR_W'(LOCKOUT_CYCLES - 1);
                        end else begin
                            w_tmr_load = 1'b0;
                        end
                    end else begin
                        w_value_nxt = r_value;
                    end
                end else begin
`ifdef ENTRY_TIMEOUT_EN
                    w_tmr_en = 1'b1;
`endif
                    w_value_nxt = r_value;
                end
            end
            ST_CHECK: begin
                w_value_nxt = EMPTY_VALUE;
                w_count_nxt = 6'd0;
                if (master_same) begin
                    w_master_nxt = 1'b1;
                    w_fails_nxt  = 2'd0;
                end else if (same) begin
                    w_unlock_nxt = 1'b1;
                    w_fails_nxt  = 2'd0;
                end else begin
                    w_fail_nxt  = 1'b1;
                    w_fails_nxt = w_fails_inc;
                    if (w_fail_hit) begin
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = TMR_W'(LOCKOUT_CYCLES - 1);
                    end else begin
                        w_tmr_load = 1'b0;
                    end
                end
            end
            ST_LOCKOUT: begin
                w_tmr_en = 1'b1;
                if (w_tmr_done) begin
                    w_fails_nxt = 2'd0;
                end else begin
                    w_fails_nxt = r_fails;
                end
            end
            default: begin
                w_value_nxt = EMPTY_VALUE;
                w_count_nxt = 6'd0;
            end
        endcase
    end

    // Registered datapath and outputs; confirm/locked follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value   <= EMPTY_VALUE;
            r_count   <= 6'd0;
            r_fails   <= 2'd0;
            r_unlock  <= 1'b0;
            r_master  <= 1'b0;
            r_fail    <= 1'b0;
            r_confirm <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_value   <= w_value_nxt;
            r_count   <= w_count_nxt;
            r_fails   <= w_fails_nxt;
            r_unlock  <= w_unlock_nxt;
            r_master  <= w_master_nxt;
            r_fail    <= w_fail_nxt;
            r_confirm <= (w_next_state == ST_CHECK);
            r_locked  <= (w_next_state == ST_LOCKOUT);
        end
    end

    assign input_value   = r_value;
    assign digit_count   = r_count;
    assign confirm       = r_confirm;
    assign unlock        = r_unlock;
    assign master_unlock = r_master;
    assign fail          = r_fail;
    assign locked        = r_locked;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer; expected values are hand-derived.
module tb_keypad_entry_buffer;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         same;
    logic         master_same;
    logic [127:0] input_value;
    logic         confirm;
    logic [5:0]   digit_count;
    logic         unlock;
    logic         master_unlock;
    logic         fail;
    logic         locked;

    int n_checks;
    int n_fails;

    localparam logic [127:0] EMPTY = {32{4'hF}};

    keypad_entry_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .same          (same),
        .master_same   (master_same),
        .input_value   (input_value),
        .confirm       (confirm),
        .digit_count   (digit_count),
        .unlock        (unlock),
        .master_unlock (master_unlock),
        .fail          (fail),
        .locked        (locked)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Present one key for exactly one rising edge; returns on the following negedge.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic short_fail();
        press(4'd1);
        press(4'd2);
        press(4'hB);
    endtask

    task automatic type_1234();
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
    endtask

    logic [127:0] exp_v;
    int           n;
    logic         seen_fail;

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        rst_n       = 1'b0;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        same        = 1'b0;
        master_same = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_value",  input_value, EMPTY);
        chk("rst_count",  {122'd0, digit_count}, 128'd0);
        chk("rst_confirm", {127'd0, confirm}, 128'd0);
        chk("rst_locked", {127'd0, locked}, 128'd0);
        chk("rst_pulses", {125'd0, unlock, master_unlock, fail}, 128'd0);
        rst_n = 1'b1;

        // Clear and enter in IDLE are ignored
        press(4'hB);
        chk("idle_enter_nofail", {127'd0, fail}, 128'd0);
        press(4'hA);
        chk("idle_count", {122'd0, digit_count}, 128'd0);

        // 1234 + enter, user code matches
        type_1234();
        exp_v = EMPTY;
        exp_v[15:0] = 16'h1234;
        chk("pack_1234", input_value, exp_v);
        chk("count_4", {122'd0, digit_count}, 128'd4);
        same = 1'b1;
        press(4'hB);
        chk("confirm_hi", {127'd0, confirm}, 128'd1);
        chk("frozen_value", input_value, exp_v);
        @(negedge clk);
        chk("unlock_pulse", {125'd0, unlock, master_unlock, fail}, 128'b100);
        chk("confirm_lo", {127'd0, confirm}, 128'd0);
        chk("cleared_after_unlock", input_value, EMPTY);
        @(negedge clk);
        chk("unlock_one_cycle", {127'd0, unlock}, 128'd0);
        same = 1'b0;

        // Short entry fails immediately (counter 1)
        short_fail();
        chk("short_fail_pulse", {125'd0, unlock, master_unlock, fail}, 128'b001);
        chk("short_no_confirm", {127'd0, confirm}, 128'd0);
        chk("short_cleared", input_value, EMPTY);
        chk("short_count0", {122'd0, digit_count}, 128'd0);
        @(negedge clk);
        chk("short_fail_one_cycle", {127'd0, fail}, 128'd0);

        // Master priority; also clears the fail counter
        type_1234();
        same        = 1'b1;
        master_same = 1'b1;
        press(4'hB);
        chk("master_confirm", {127'd0, confirm}, 128'd1);
        @(negedge clk);
        chk("master_only", {125'd0, unlock, master_unlock, fail}, 128'b010);
        same        = 1'b0;
        master_same = 1'b0;

        // Three failures from zero: lock only on the third
        short_fail();
        short_fail();
        chk("two_fails_unlocked", {127'd0, locked}, 128'd0);
        type_1234();
        press(4'hB);
        chk("third_confirm", {127'd0, confirm}, 128'd1);
        @(negedge clk);
        chk("third_fail_pulse", {125'd0, unlock, master_unlock, fail}, 128'b001);
        chk("locked_set", {127'd0, locked}, 128'd1);

        // Lockout length with keys sprinkled in
        n = 1;
        while (n < 1100) begin
            @(negedge clk);
            key_valid = 1'b0;
            if (!locked) break;
            n++;
            if ((n % 97) == 3) begin
                key_valid = 1'b1;
                key_code  = ((n % 2) == 1) ? 4'h7 : 4'hB;
            end
        end
        key_valid = 1'b0;
        chk("lockout_cycles", 128'(n), 128'd1000);
        chk("lockout_keys_lost", {122'd0, digit_count}, 128'd0);
        chk("lockout_value", input_value, EMPTY);

        // Counter cleared after lockout: two more fails do not lock
        short_fail();
        short_fail();
        @(negedge clk);
        chk("post_lockout_counter0", {127'd0, locked}, 128'd0);
        type_1234();
        same = 1'b1;
        press(4'hB);
        @(negedge clk);
        chk("post_lockout_unlock", {127'd0, unlock}, 128'd1);
        same = 1'b0;

        // 33 digits: the last one is dropped
        exp_v = EMPTY;
        for (int i = 0; i < 33; i++) begin
            press(4'(i % 10));
            if (i < 32) exp_v = {exp_v[123:0], 4'(i % 10)};
        end
        chk("full_count", {122'd0, digit_count}, 128'd32);
        chk("full_value", input_value, exp_v);
        press(4'hA);
        chk("clear_value", input_value, EMPTY);
        chk("clear_count", {122'd0, digit_count}, 128'd0);
        chk("clear_nofail", {127'd0, fail}, 128'd0);

        // Reset asserted during CHECK
        type_1234();
        same = 1'b1;
        press(4'hB);
        chk("pre_reset_confirm", {127'd0, confirm}, 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_check_confirm", {127'd0, confirm}, 128'd0);
        chk("rst_check_value", input_value, EMPTY);
        chk("rst_check_count", {122'd0, digit_count}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_check_nopulse", {125'd0, unlock, master_unlock, fail}, 128'd0);
        same = 1'b0;

`ifdef ENTRY_TIMEOUT_EN
        // Idle timeout abandons the attempt silently
        seen_fail = 1'b0;
        press(4'd5);
        chk("to_count1", {122'd0, digit_count}, 128'd1);
        repeat (4999) begin
            @(negedge clk);
            if (fail) seen_fail = 1'b1;
        end
        chk("to_not_yet", {122'd0, digit_count}, 128'd1);
        @(negedge clk);
        if (fail) seen_fail = 1'b1;
        chk("to_count0", {122'd0, digit_count}, 128'd0);
        chk("to_value", input_value, EMPTY);
        @(negedge clk);
        if (fail) seen_fail = 1'b1;
        chk("to_nofail", {127'd0, seen_fail}, 128'd0);
`else
        seen_fail = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
